demux_lanes_param: RTL

//  Parametrised single-clock lane demultiplexer, successor to the fixed 2->4 L1 demux.

---
 rtl/demux_lanes_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/demux_lanes_param.sv
`default_nettype none
// ============================================================================
//  Module      : demux_lanes_param
//  Description : Parametrised single-clock lane demultiplexer. Gathers FANOUT
//                consecutive words from each of IN_LANES input lanes and
//                presents them in parallel once per frame, together with a
//                one-cycle frame strobe and a per-lane partial-frame flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_lanes_param #(
    parameter int W        = 8,
    parameter int IN_LANES = 2,
    parameter int FANOUT   = 2,
    parameter int HOLD_INV = 1
) (
    input  logic                            clk_2f,
    input  logic                            reset,
    input  logic [IN_LANES*W-1:0]           data_in,
    input  logic [IN_LANES-1:0]             valid_in,
    output logic [IN_LANES*FANOUT*W-1:0]    data_out,
    output logic [IN_LANES*FANOUT-1:0]      valid_out,
    output logic                            frame_stb,
    output logic [$clog2(FANOUT)-1:0]       phase,
    output logic [IN_LANES-1:0]             part_err
);

    localparam int                    c_phase_w   = $clog2(FANOUT);
    localparam logic [c_phase_w-1:0]  c_last_slot = c_phase_w'(FANOUT - 1);

    // Slot counter: free-running, wraps naturally because FANOUT is a power of 2.
    logic [c_phase_w-1:0]                      phase_q, phase_d;

    // Shadow storage for every slot except the last; the last slot is taken
    // straight from the inputs on the commit edge.
    logic [IN_LANES-1:0][FANOUT-2:0][W-1:0]    shadow_q, shadow_d;
    logic [IN_LANES-1:0][FANOUT-2:0]           shv_q, shv_d;

    logic [IN_LANES*FANOUT*W-1:0]              data_out_q, data_out_d;
    logic [IN_LANES*FANOUT-1:0]                valid_out_q, valid_out_d;
    logic                                      frame_stb_q, frame_stb_d;
    logic [IN_LANES-1:0]                       part_err_q, part_err_d;

    // Complete frame as seen on the commit edge: stored slots plus the live last slot.
    logic [IN_LANES-1:0][FANOUT-1:0][W-1:0]    w_slot_data;
    logic [IN_LANES-1:0][FANOUT-1:0]           w_slot_valid;

    for (genvar j = 0; j < IN_LANES; j++) begin : g_lane
        for (genvar k = 0; k < FANOUT; k++) begin : g_slot
            if (k < FANOUT - 1) begin : g_stored
                assign w_slot_data[j][k]  = shadow_q[j][k];
                assign w_slot_valid[j][k] = shv_q[j][k];
            end else begin : g_live
                assign w_slot_data[j][k]  = data_in[j*W +: W];
                assign w_slot_valid[j][k] = valid_in[j];
            end
        end
    end

    // Next-state: capture into the current slot, or commit the whole frame on the last slot.
    always_comb begin
        phase_d     = phase_q + 1'b1;
        shadow_d    = shadow_q;
        shv_d       = shv_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        frame_stb_d = 1'b0;
        part_err_d  = '0;

        if (phase_q == c_last_slot) begin
            frame_stb_d = 1'b1;
            for (int j = 0; j < IN_LANES; j++) begin
                for (int k = 0; k < FANOUT; k++) begin
                    valid_out_d[j*FANOUT + k] = w_slot_valid[j][k];
                    if (w_slot_valid[j][k]) begin
                        data_out_d[(j*FANOUT + k)*W +: W] = w_slot_data[j][k];
                    end else if (HOLD_INV == 0) begin
                        data_out_d[(j*FANOUT + k)*W +: W] = '0;
                    end
                end
                // Mixed frame: at least one valid and at least one invalid slot.
                part_err_d[j] = (|w_slot_valid[j]) && !(&w_slot_valid[j]);
            end
        end else begin
            for (int j = 0; j < IN_LANES; j++) begin
                for (int k = 0; k < FANOUT - 1; k++) begin
                    if (phase_q == c_phase_w'(k)) begin
                        shadow_d[j][k] = data_in[j*W +: W];
                        shv_d[j][k]    = valid_in[j];
                    end
                end
            end
        end
    end

    // State registers; reset drops any partial frame and restarts at slot 0.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            phase_q     <= '0;
            shadow_q    <= '0;
            shv_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= '0;
            frame_stb_q <= 1'b0;
            part_err_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            shv_q       <= shv_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            frame_stb_q <= frame_stb_d;
            part_err_q  <= part_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign frame_stb = frame_stb_q;
    assign phase     = phase_q;
    assign part_err  = part_err_q;

endmodule
`default_nettype wire
